// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
// Holds the fetch FSM states, datapath width, PC step and default reset PC.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, requests imem, holds the word
// for execute and picks the next PC on retire (branch target or PC+4).
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   imem_req/addr/ready         fetch request handshake (addr = PC)
//   imem_rvalid/rdata           fetch response
//   instr_valid/instr/instr_pc  instruction presented to execute
//   retire, stall               consume / hold the presented instruction
//   branch_taken/target         next-PC selection from branch control
//   halted                      stopped on a misaligned next PC
//   instret                     retired instruction count
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            retire,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            halted,
    output logic [XLEN-1:0] instret
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic [XLEN-1:0] instret_q;

    logic [XLEN-1:0] next_pc_d;
    logic            retire_go;

    // Next-PC mux: a taken branch replaces the sequential step entirely.
    assign next_pc_d = branch_taken ? branch_target : pc_q + PC_STEP;

    // Retire while stalled is ignored.
    assign retire_go = retire && !stall;

    // Gated by rst_n so no request escapes while reset is held,
    // even though the state already reads REQ.
    assign imem_req    = rst_n && (state_q == REQ) && !stall;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign halted      = (state_q == HALT);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instret     = instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
            instret_q  <= '0;
        end else begin
            unique case (state_q)
                REQ: begin
                    // Responses arriving here (e.g. left over from before
                    // a reset) are deliberately not looked at.
                    if (imem_req && imem_ready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // stall is not consulted: the response is always taken.
                    if (imem_rvalid) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (retire_go) begin
                        instret_q <= instret_q + 32'd1;
                        if (next_pc_d[1:0] != 2'b00) begin
                            // pc keeps the last aligned value.
                            state_q <= HALT;
                        end else begin
                            pc_q    <= next_pc_d;
                            state_q <= REQ;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= REQ;
                end
            endcase
        end
    end

endmodule
